// File: rtl/core_pkg.sv
// Shared execute-stage definitions: divider operation/state encodings and constants.
package core_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } div_state_t;

    localparam int unsigned DIV_STEPS = 32;
    localparam int unsigned CNT_W     = 6;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES  = 32'hFFFF_FFFF;

    function automatic logic is_signed_op(input div_op_t op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic is_rem_op(input div_op_t op);
        return (op == REM) || (op == REMU);
    endfunction

    // Two's-complement negate when en is set, pass-through otherwise.
    function automatic logic [31:0] neg_if(input logic [31:0] x, input logic en);
        return en ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/core_div_step.sv
// One restoring-division iteration: trial subtract, restore select, quotient bit.
module core_div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] q_i,
    input  logic [XLEN-1:0] div_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] q_o
);

    logic [XLEN:0] w_shifted;
    logic [XLEN:0] w_trial;

    assign w_shifted = {rem_i, q_i[XLEN-1]};
    assign w_trial   = w_shifted - {1'b0, div_i};

    // Sign bit of the trial tells whether the divisor fit.
    always_comb begin
        if (!w_trial[XLEN]) begin
            rem_o = w_trial[XLEN-1:0];
            q_o   = {q_i[XLEN-2:0], 1'b1};
        end else begin
            rem_o = w_shifted[XLEN-1:0];
            q_o   = {q_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/core_divider.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU), restoring, one quotient bit per cycle.
module core_divider
    import core_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    div_state_t       r_state,   w_state;
    div_op_t          r_op,      w_op;
    logic             r_neg_q,   w_neg_q;
    logic             r_neg_r,   w_neg_r;
    logic             r_special, w_special;
    logic [CNT_W-1:0] r_count,   w_count;
    logic [XLEN-1:0]  r_q,       w_q;
    logic [XLEN-1:0]  r_rem,     w_rem;
    logic [XLEN-1:0]  r_div,     w_div;
    logic             r_busy,    w_busy;
    logic             r_done,    w_done;
    logic [XLEN-1:0]  r_result,  w_result;

    logic [XLEN-1:0]  w_step_rem;
    logic [XLEN-1:0]  w_step_q;

    div_op_t          w_op_in;
    logic             w_signed_in;
    logic             w_sa;
    logic             w_sb;
    logic [XLEN-1:0]  w_mag_a;
    logic [XLEN-1:0]  w_mag_b;
    logic             w_div_zero;
    logic             w_overflow;
    logic [XLEN-1:0]  w_fix_val;
    logic             w_fix_neg;

    core_div_step #(.XLEN(XLEN)) u_step (
        .rem_i (r_rem),
        .q_i   (r_q),
        .div_i (r_div),
        .rem_o (w_step_rem),
        .q_o   (w_step_q)
    );

    // Request decode: operand magnitudes, sign flags and special cases.
    assign w_op_in     = div_op_t'(op_i);
    assign w_signed_in = is_signed_op(w_op_in);
    assign w_sa        = w_signed_in & a_i[XLEN-1];
    assign w_sb        = w_signed_in & b_i[XLEN-1];
    assign w_mag_a     = neg_if(a_i, w_sa);
    assign w_mag_b     = neg_if(b_i, w_sb);
    assign w_div_zero  = (b_i == '0);
    assign w_overflow  = w_signed_in && (a_i == INT_MIN) && (b_i == ALL_ONES);

    // Special-case answers are preloaded and must not be sign-corrected.
    assign w_fix_val   = is_rem_op(r_op) ? r_rem : r_q;
    assign w_fix_neg   = !r_special && (is_rem_op(r_op) ? r_neg_r : r_neg_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_op      <= DIV;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_special <= 1'b0;
            r_count   <= '0;
            r_q       <= '0;
            r_rem     <= '0;
            r_div     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
        end else begin
            r_state   <= w_state;
            r_op      <= w_op;
            r_neg_q   <= w_neg_q;
            r_neg_r   <= w_neg_r;
            r_special <= w_special;
            r_count   <= w_count;
            r_q       <= w_q;
            r_rem     <= w_rem;
            r_div     <= w_div;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_result  <= w_result;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_op      = r_op;
        w_neg_q   = r_neg_q;
        w_neg_r   = r_neg_r;
        w_special = r_special;
        w_count   = r_count;
        w_q       = r_q;
        w_rem     = r_rem;
        w_div     = r_div;
        w_done    = 1'b0;
        w_result  = r_result;

        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_op    = w_op_in;
                    w_neg_q = w_sa ^ w_sb;
                    w_neg_r = w_sa;
                    w_count = '0;
                    w_div   = w_mag_b;
                    if (w_div_zero) begin
                        w_q       = ALL_ONES;
                        w_rem     = a_i;
                        w_special = 1'b1;
                        w_state   = FIX;
                    end else if (w_overflow) begin
                        w_q       = INT_MIN;
                        w_rem     = '0;
                        w_special = 1'b1;
                        w_state   = FIX;
                    end else begin
                        w_q       = w_mag_a;
                        w_rem     = '0;
                        w_special = 1'b0;
                        w_state   = CALC;
                    end
                end
            end
            CALC: begin
                w_q     = w_step_q;
                w_rem   = w_step_rem;
                w_count = r_count + CNT_W'(1);
                if (r_count == CNT_W'(DIV_STEPS - 1)) begin
                    w_state = FIX;
                end
            end
            FIX: begin
                w_result = neg_if(w_fix_val, w_fix_neg);
                w_done   = 1'b1;
                w_state  = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase

        // Busy also covers the done cycle so the stall releases one cycle after completion.
        w_busy = (w_state != IDLE) || (r_state == FIX);
    end

    assign busy_o   = r_busy;
    assign done_o   = r_done;
    assign result_o = r_result;

endmodule
